// File: rtl/seg_scan.sv
// seg_scan: scan driver for an 8-digit 7-segment display.
// Holds a 32-bit shadow value and steps through its eight nibbles at a
// programmable rate. Each nibble goes to an external hex decoder as a 5-bit
// code, and the decoder's segment map comes back to be registered onto the
// pins together with the matching active-low anode.
// Optional feature: define SEG_SCAN_LZS_EN for leading-zero suppression.

// Per-digit code former: passes the nibble through, or forces the blank code.
module seg_lane (
  input  logic [3:0] nib,
  input  logic       sup,
  output logic [4:0] code
);
  assign code = sup ? 5'd31 : {1'b0, nib};
endmodule

module seg_scan #(
  parameter int CLK_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data,
  input  logic        load,
  input  logic [7:0]  blank,
  output logic [4:0]  digit,
  input  logic [6:0]  map,
  output logic [7:0]  an,
  output logic [6:0]  seg
);
  localparam int NUM_DIG = 8;
  localparam int NIB_W   = 4;
  localparam int CODE_W  = 5;
  // The prescaler keeps at least one bit so that CLK_DIV=1 still elaborates.
  localparam int PCW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PCW-1:0] PC_MAX = PCW'(CLK_DIV - 1);

  logic [NUM_DIG-1:0][NIB_W-1:0]  shd;
  logic [NUM_DIG-1:0][CODE_W-1:0] code;
  logic [NUM_DIG-1:0]             sup;
  logic [PCW-1:0]                 pc;
  logic                           tick;
  logic [2:0]                     idx;
  logic [2:0]                     idx1;
  logic                           vld1;

  assign tick = (pc == PC_MAX);

`ifdef SEG_SCAN_LZS_EN
  // Digit k (k>=1) goes dark when it and every digit to its left are zero.
  // Digit 0 is never suppressed, so a zero value still shows "0".
  for (genvar k = 0; k < NUM_DIG; k++) begin : g_lzs
    if (k == 0) begin : g_d0
      assign sup[k] = blank[k];
    end else begin : g_dk
      assign sup[k] = blank[k] | ~|shd[NUM_DIG-1:k];
    end
  end
`else
  assign sup = blank;
`endif

  seg_lane u_lane [NUM_DIG-1:0] (
    .nib  (shd),
    .sup  (sup),
    .code (code)
  );

  // Shadow register: capture the display value on load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       shd <= '0;
    else if (load) shd <= data;
  end

  // Slot prescaler and scan index; idx advances once per CLK_DIV cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc  <= '0;
      idx <= '0;
    end else if (tick) begin
      pc  <= '0;
      idx <= idx + 3'd1;
    end else begin
      pc  <= pc + 1'b1;
    end
  end

  // Stage 1: select the current digit's code for the decoder, every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit <= 5'd31;
      idx1  <= '0;
      vld1  <= 1'b0;
    end else begin
      digit <= code[idx];
      idx1  <= idx;
      vld1  <= 1'b1;
    end
  end

  // Stage 2: anode and segments register on the same edge so that they stay
  // matched. The anode is held off until stage 1 has carried a real digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= 8'hFF;
      seg <= 7'h7F;
    end else begin
      an  <= vld1 ? ~(8'b1 << idx1) : 8'hFF;
      seg <= ~map;
    end
  end
endmodule
